// File: rtl/fifo_drain_ctrl.sv
// Read-side controller for fifo_mem: pops in threshold bursts or full flushes,
// realigns returned data to the read latency and buffers it onto a valid/ready stream.
module fifo_drain_ctrl #(
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1,
    parameter int BURST_LEN  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic              fifo_threshold,
    output logic              fifo_rd,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic [15:0]       pop_count
);
    // state | meaning
    // IDLE  | waiting for a pending flush or the threshold flag
    // BURST | popping up to BURST_LEN bytes
    // FLUSH | popping until the FIFO reports empty
    // DRAIN | no pops; waiting for in-flight reads and the output buffer to empty
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  flush_pend_q, flush_pend_d;
    logic [3:0]            remain_q, remain_d;
    logic [RD_LATENCY-1:0] pipe_q, pipe_d;
    logic [DATA_W-1:0]     buf_q [4];
    logic [1:0]            wr_ptr_q, rd_ptr_q;
    logic [2:0]            count_q, count_d;
    logic [15:0]           pop_count_q;
    logic [2:0]            inflight;
    logic                  credit_ok;
    logic                  buf_push;
    logic                  buf_pop;
    logic                  flush_req;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + {2'b00, pipe_q[i]};
        end
    end

    // Credit covers both buffered bytes and reads still in the FIFO pipe, so the buffer cannot overflow.
    assign credit_ok = ({1'b0, count_q} + {1'b0, inflight}) < 4'd4;
    assign fifo_rd   = ((state_q == S_BURST && remain_q != 4'd0) || state_q == S_FLUSH)
                       && !fifo_empty && credit_ok;
    assign pipe_d    = RD_LATENCY'({pipe_q, fifo_rd});
    assign buf_push  = pipe_q[RD_LATENCY-1];
    assign m_valid   = (count_q != 3'd0);
    assign buf_pop   = m_valid && m_ready;
    assign count_d   = count_q + {2'b00, buf_push} - {2'b00, buf_pop};
    assign flush_req = flush || flush_pend_q;
    assign m_data    = buf_q[rd_ptr_q];
    assign busy      = (state_q != S_IDLE);
    assign pop_count = pop_count_q;

    always_comb begin
        state_d      = state_q;
        remain_d     = remain_q;
        flush_pend_d = flush_pend_q || flush;
        case (state_q)
            S_IDLE: begin
                flush_pend_d = 1'b0;
                if (flush_req && !fifo_empty) begin
                    state_d = S_FLUSH;
                end else if (fifo_threshold && !fifo_empty) begin
                    state_d  = S_BURST;
                    remain_d = 4'(BURST_LEN);
                end
            end
            S_BURST: begin
                if (fifo_rd) begin
                    remain_d = remain_q - 4'd1;
                end
                if (fifo_empty || remain_d == 4'd0) begin
                    state_d = S_DRAIN;
                end
            end
            S_FLUSH: begin
                if (fifo_empty) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (inflight == 3'd0 && count_q == 3'd0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            flush_pend_q <= 1'b0;
            remain_q     <= 4'd0;
            pipe_q       <= '0;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            count_q      <= 3'd0;
            pop_count_q  <= 16'd0;
            for (int i = 0; i < 4; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            remain_q     <= remain_d;
            pipe_q       <= pipe_d;
            count_q      <= count_d;
            pop_count_q  <= pop_count_q + {15'd0, fifo_rd};
            if (buf_push) begin
                buf_q[wr_ptr_q] <= fifo_data;
            end
            wr_ptr_q <= wr_ptr_q + {1'b0, buf_push};
            rd_ptr_q <= rd_ptr_q + {1'b0, buf_pop};
        end
    end
endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: two instances (read latency 1 and 2) fed from identical FIFO
// models and checked every cycle against an in-order byte scoreboard plus directed scenarios.
module tb_fifo_drain_ctrl;
    localparam int BL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_threshold = 1'b0;
    logic       flush = 1'b0;
    logic       m_ready = 1'b0;
    logic [1:0] fifo_empty_w = 2'b11;
    logic [1:0] fifo_rd_w;
    logic [1:0] m_valid_w;
    logic [1:0] busy_w;
    logic [7:0] fifo_data_w [2];
    logic [7:0] m_data_w [2];
    logic [15:0] pop_count_w [2];

    fifo_drain_ctrl #(.DATA_W(8), .RD_LATENCY(1), .BURST_LEN(BL)) u_dut_l1 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty_w[0]), .fifo_threshold(fifo_threshold),
        .fifo_rd(fifo_rd_w[0]), .fifo_data(fifo_data_w[0]), .flush(flush),
        .m_valid(m_valid_w[0]), .m_ready(m_ready), .m_data(m_data_w[0]),
        .busy(busy_w[0]), .pop_count(pop_count_w[0])
    );

    fifo_drain_ctrl #(.DATA_W(8), .RD_LATENCY(2), .BURST_LEN(BL)) u_dut_l2 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty_w[1]), .fifo_threshold(fifo_threshold),
        .fifo_rd(fifo_rd_w[1]), .fifo_data(fifo_data_w[1]), .flush(flush),
        .m_valid(m_valid_w[1]), .m_ready(m_ready), .m_data(m_data_w[1]),
        .busy(busy_w[1]), .pop_count(pop_count_w[1])
    );

    initial forever #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [7:0] fq [2][$];
    int         exp_d [2][$];
    int         exp_c [2][$];
    int         log_d [2][$];
    int         hs_cyc [2][$];
    int         rd_cyc [2][$];
    logic [15:0] pops [2];
    logic [1:0] rd_s = 2'b00;
    logic [7:0] stage1 = 8'h00;
    int         rb [2];
    int         lb [2];
    bit         drained;

    task automatic chk(input string name, input int k, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s inst%0d: got 0x%0h required 0x%0h (cycle %0d)", name, k, act, req, cyc);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    // A popped byte must head the stream exactly latency+1 cycles after its pop, in pop order.
    task automatic compare();
        logic exp_v;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                exp_d[k].delete();
                exp_c[k].delete();
                pops[k] = 16'd0;
            end else begin
                exp_v = 1'b0;
                if (exp_d[k].size() > 0) exp_v = (cyc - exp_c[k][0]) >= (k + 2);
                chk("m_valid", k, int'(m_valid_w[k]), int'(exp_v));
                if (exp_v) chk("m_data", k, int'(m_data_w[k]), exp_d[k][0]);
                chk("pop_count", k, int'(pop_count_w[k]), int'(pops[k]));
                chk("rd_on_empty", k, int'(fifo_rd_w[k] & fifo_empty_w[k]), 0);
                if (fifo_rd_w[k]) begin
                    chk("credit", k, int'(exp_d[k].size() < 4), 1);
                    chk("busy_on_rd", k, int'(busy_w[k]), 1);
                end
                if (exp_v && m_ready) begin
                    log_d[k].push_back(exp_d[k][0]);
                    hs_cyc[k].push_back(cyc);
                    void'(exp_d[k].pop_front());
                    void'(exp_c[k].pop_front());
                end
                if (fifo_rd_w[k]) begin
                    pops[k] = pops[k] + 16'd1;
                    exp_d[k].push_back(fq[k].size() > 0 ? int'(fq[k][0]) : 32'hEE);
                    exp_c[k].push_back(cyc);
                    rd_cyc[k].push_back(cyc);
                end
            end
            rd_s[k] = fifo_rd_w[k];
        end
    endtask

    task automatic fifo_update();
        logic [7:0] b;
        for (int k = 0; k < 2; k++) begin
            b = 8'h00;
            if (rd_s[k] && fq[k].size() > 0) b = fq[k].pop_front();
            if (k == 0) begin
                if (rd_s[0]) fifo_data_w[0] = b;
            end else begin
                fifo_data_w[1] = stage1;
                stage1 = b;
            end
            fifo_empty_w[k] = (fq[k].size() == 0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        fifo_update();
        cyc++;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int k = 0; k < 2; k++) begin
            fq[k].push_back(b);
            fifo_empty_w[k] = 1'b0;
        end
    endtask

    task automatic reset_dut();
        fifo_threshold = 1'b0;
        flush = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) fq[k].delete();
        fifo_empty_w = 2'b11;
    endtask

    task automatic snap();
        for (int k = 0; k < 2; k++) begin
            rb[k] = rd_cyc[k].size();
            lb[k] = log_d[k].size();
        end
    endtask

    task automatic wait_idle(input int bound, input bit need_empty);
        bit done;
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            tick();
            #1;
            done = (busy_w == 2'b00) && (exp_d[0].size() == 0) && (exp_d[1].size() == 0)
                   && (!need_empty || (fq[0].size() == 0 && fq[1].size() == 0));
        end
        chk("idle_within_bound", 0, int'(done), 1);
    endtask

    task automatic chk_log(input string name, input int k, input int first, input int n);
        chk({name, "_count"}, k, log_d[k].size() - lb[k], n);
        for (int i = 0; i < n; i++) chk(name, k, at(log_d[k], lb[k] + i), first + i);
    endtask

    initial begin
        fifo_data_w[0] = 8'h00;
        fifo_data_w[1] = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_m_valid", k, int'(m_valid_w[k]), 0);
            chk("rst_busy", k, int'(busy_w[k]), 0);
            chk("rst_pop_count", k, int'(pop_count_w[k]), 0);
            chk("rst_m_data", k, int'(m_data_w[k]), 0);
            chk("rst_fifo_rd", k, int'(fifo_rd_w[k]), 0);
        end

        // threshold burst: 6 queued, exactly BURST_LEN pops
        reset_dut();
        for (int i = 1; i <= 6; i++) push_byte(8'(i));
        m_ready = 1'b1;
        snap();
        fifo_threshold = 1'b1;
        tick();
        fifo_threshold = 1'b0;
        wait_idle(60, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk("burst_rd_pulses", k, rd_cyc[k].size() - rb[k], 4);
            chk("burst_pop_count", k, int'(pop_count_w[k]), 4);
            chk("burst_busy_end", k, int'(busy_w[k]), 0);
            chk_log("burst_stream", k, 1, 4);
            chk("first_valid_latency", k, at(hs_cyc[k], lb[k]) - at(rd_cyc[k], rb[k]), k + 2);
            chk("sustained_rate", k, at(hs_cyc[k], lb[k] + 3) - at(hs_cyc[k], lb[k]), 3);
        end

        // flush of 3 bytes
        reset_dut();
        for (int i = 0; i < 3; i++) push_byte(8'(8'h0A + i));
        snap();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_idle(60, 1'b1);
        for (int k = 0; k < 2; k++) begin
            chk("flush_rd_pulses", k, rd_cyc[k].size() - rb[k], 3);
            chk("flush_pop_count", k, int'(pop_count_w[k]), 3);
            chk_log("flush_stream", k, 8'h0A, 3);
        end

        // backpressure during a flush of 8
        reset_dut();
        for (int i = 1; i <= 8; i++) push_byte(8'(i));
        m_ready = 1'b0;
        snap();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (20) tick();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("stall_pop_count", k, int'(pop_count_w[k]), 4);
            chk("stall_m_valid", k, int'(m_valid_w[k]), 1);
            chk("stall_m_data", k, int'(m_data_w[k]), 1);
        end
        m_ready = 1'b1;
        wait_idle(100, 1'b1);
        for (int k = 0; k < 2; k++) begin
            chk("bp_pop_count", k, int'(pop_count_w[k]), 8);
            chk_log("bp_stream", k, 1, 8);
        end

        // reset with bytes in flight and buffered
        reset_dut();
        for (int i = 1; i <= 8; i++) push_byte(8'(i));
        m_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("midrst_m_valid", k, int'(m_valid_w[k]), 0);
            chk("midrst_busy", k, int'(busy_w[k]), 0);
            chk("midrst_pop_count", k, int'(pop_count_w[k]), 0);
            chk("midrst_fifo_left", k, fq[k].size(), 4);
        end
        snap();
        m_ready = 1'b1;
        repeat (10) tick();
        for (int k = 0; k < 2; k++) chk("midrst_no_stale", k, log_d[k].size() - lb[k], 0);

        // flush arriving mid-burst with 10 queued
        reset_dut();
        for (int i = 1; i <= 10; i++) push_byte(8'(i));
        m_ready = 1'b1;
        snap();
        fifo_threshold = 1'b1;
        tick();
        fifo_threshold = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_idle(100, 1'b1);
        for (int k = 0; k < 2; k++) begin
            chk("fdb_pop_count", k, int'(pop_count_w[k]), 10);
            chk_log("fdb_stream", k, 1, 10);
            chk("fdb_burst_gap", k,
                int'((at(rd_cyc[k], rb[k] + 4) - at(rd_cyc[k], rb[k] + 3)) > 1), 1);
        end

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            fifo_threshold = ($urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 2) == 0 && fq[0].size() < 16) push_byte(8'($urandom_range(0, 255)));
            tick();
        end
        rst = 1'b0;
        flush = 1'b0;
        fifo_threshold = 1'b0;
        m_ready = 1'b1;
        drained = 1'b0;
        for (int i = 0; i < 400 && !drained; i++) begin
            flush = (busy_w == 2'b00) && (fq[0].size() + fq[1].size() > 0);
            tick();
            flush = 1'b0;
            #1;
            drained = (busy_w == 2'b00) && (exp_d[0].size() + exp_d[1].size() == 0)
                      && (fq[0].size() + fq[1].size() == 0);
        end
        chk("final_drain", 0, int'(drained), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
